mult_nbits_seq: RTL and testbench
=================================

# mult_nbits_seq

Parametrised sequential shift-and-add multiplier. It is the successor to the fixed 4-bit `mult4bits` unit, generalised to any operand width. It adds a signed (two's-complement) mode, a configurable output width with a true overflow flag, and a `busy` status. It sits in the lab datapath wherever a multi-cycle multiply is started by an `init` strobe and consumed on `done`.

## Interface

Parameters:
- `WIDTH`, default 4: operand width of `MD` and `MR`, ≥2.
- `OUT_WIDTH`, default 8 (2·`WIDTH`): width of `PP`, from `WIDTH` to 2·`WIDTH`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `init` in 1: start request, level-sampled in IDLE.
- `signed_mode` in 1: 1 = operands and product are two's complement; sampled at start.
- `MD` in `WIDTH`: multiplicand, sampled at start.
- `MR` in `WIDTH`: multiplier, sampled at start.
- `PP` out `OUT_WIDTH`: product, low `OUT_WIDTH` bits of the exact product.
- `done` out 1: result valid; high for the whole DONE state.
- `busy` out 1: high in CALC and FIX.
- `overflow` out 1: exact product not representable in `OUT_WIDTH` bits under the sampled mode.
- `zero` out 1: exact product equals 0.

## Operation

- FSM states: IDLE, CALC, FIX, DONE. All outputs are registered.
- **IDLE**
  - `init`=1 at an edge: latch `signed_mode`, and latch |MD| and |MR| (raw values if unsigned).
  - Latch result sign = MD[msb] ^ MR[msb] (signed mode only).
  - Clear the 2·`WIDTH` accumulator; load counter = `WIDTH`; go to CALC.
  - `PP` and the flags keep their previous values until FIX.
- **CALC**
  - One iteration per cycle: if multiplier LSB = 1, add the shifted multiplicand to the accumulator.
  - Shift multiplier right and multiplicand left; decrement counter.
  - When counter reaches 0, go to FIX.
- **FIX** (one cycle)
  - Negate the accumulator if signed mode and sign = 1.
  - `PP` ← low `OUT_WIDTH` bits; `zero` ← (exact product == 0).
  - `overflow` ← upper bits [2W-1:OUT_WIDTH] nonzero (unsigned), or not a sign-extension of bit `OUT_WIDTH`-1 (signed).
  - Go to DONE.
- **DONE**
  - `done`=1; results held stable.
  - Go to IDLE only when `init`=0, so a held `init` never retriggers.
- Width rules:
  - Magnitude of the most-negative operand (e.g. −8 at W=4) is taken as `WIDTH`-bit unsigned; no loss.
  - Accumulator is 2·`WIDTH` bits; this cannot overflow.
- `init` in CALC/FIX is ignored. `MD`, `MR` and `signed_mode` changes after the start edge have no effect.

## Timing

- Reset values: `PP`=0, `done`=0, `busy`=0, `overflow`=0, `zero`=0, state IDLE, accumulator and counter 0.
- Start edge E (IDLE, `init`=1):
  - `busy`=1 from E to E+`WIDTH`+1.
  - `done`=1 and results valid from edge E+`WIDTH`+1.
  - Latency is `WIDTH`+1 cycles (5 at W=4).
- Back-to-back operations: deassert `init` for ≥1 cycle in DONE, then reassert. Minimum cycle period is `WIDTH`+3 cycles.
- `rst` in any state, including mid-CALC: on the next edge all outputs and state return to their reset values; the partial result is discarded.
- `rst` and `init` high at the same edge: reset wins.

## Structure

- Package `mult_pkg` holds:
  - the FSM state encoding localparams;
  - the counter-width function (clog2 of `WIDTH`+1).
- Sub-module `twos_abs` is natural here: a combinational conditional negate/abs, parametrised by width. It is instantiated for operand magnitudes (`WIDTH`) and for result negation (2·`WIDTH`).
- The top level holds the FSM, counter, shift registers and accumulator.

## Test plan

All scenarios use W=4, OUT=8 unless stated.

- Unsigned 3×3, single-cycle `init` → `PP`=0x09, `done` at start+5 edges, `busy` high 5 cycles, `overflow`=0, `zero`=0.
- Signed −2×3 (MD=4'b1110, MR=4'b0011) → `PP`=0xFA, `overflow`=0. Signed −8×−8 → `PP`=0x40, `overflow`=0.
- Unsigned 0×7 → `PP`=0, `zero`=1. Then 6×7 with `init` held 2 cycles → `PP`=0x2A. `init` held high through DONE produces no restart; release then reassert starts a new operation.
- OUT=6, unsigned 15×15 → `PP`=6'h21, `overflow`=1. Signed −8×−8 at OUT=6 → `overflow`=1 (64 exceeds 31).
- `rst` pulsed at the 2nd CALC cycle → next edge: `busy`=0, `done`=0, `PP`=0. The following start with 5×4 → `PP`=0x14 at normal latency.
- W=8, OUT=16, signed −128×−128 → `PP`=0x4000, `done` at start+9 edges.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: state encoding
// and counter sizing.
package mult_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_FIX_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

  // Bits needed to hold an iteration count from 0 up to and including w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/twos_abs.sv
// Combinational conditional two's-complement negate; with neg_i tied to the sign
// bit it yields the magnitude, which for the most-negative value is still exact.
module twos_abs #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    if (neg_i) y_o = ~a_i + W'(1);
  end

endmodule

// File: rtl/mult_nbits_seq.sv
// Parametrised sequential shift-and-add multiplier with signed mode, truncated
// product width and overflow/zero status.
module mult_nbits_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OUT_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     MD,
  input  logic [WIDTH-1:0]     MR,
  output logic [OUT_WIDTH-1:0] PP,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 zero
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_e            state_q;
  logic [AW-1:0]     md_q;
  logic [AW-1:0]     acc_q;
  logic [WIDTH-1:0]  mr_q;
  logic [CW-1:0]     cnt_q;
  logic              smode_q;
  logic              sign_q;

  logic [WIDTH-1:0]  md_abs;
  logic [WIDTH-1:0]  mr_abs;
  logic [AW-1:0]     acc_d;
  logic [AW-1:0]     prod;
  logic              ovf_unsigned;
  logic              ovf_signed;
  logic              ovf;

  twos_abs #(.W(WIDTH)) u_md_abs (
    .a_i   (MD),
    .neg_i (signed_mode & MD[WIDTH-1]),
    .y_o   (md_abs)
  );

  twos_abs #(.W(WIDTH)) u_mr_abs (
    .a_i   (MR),
    .neg_i (signed_mode & MR[WIDTH-1]),
    .y_o   (mr_abs)
  );

  // Restores the product sign after the magnitude multiply.
  twos_abs #(.W(AW)) u_res_neg (
    .a_i   (acc_q),
    .neg_i (smode_q & sign_q),
    .y_o   (prod)
  );

  always_comb begin
    acc_d = acc_q;
    if (mr_q[0]) acc_d = acc_q + md_q;
  end

  // Overflow only exists when the output drops bits of the 2*WIDTH product.
  if (OUT_WIDTH < AW) begin : g_trunc
    logic [AW-OUT_WIDTH:0] top_bits;
    assign top_bits     = prod[AW-1:OUT_WIDTH-1];
    assign ovf_unsigned = |top_bits[AW-OUT_WIDTH:1];
    assign ovf_signed   = !((&top_bits) || !(|top_bits));
  end else begin : g_full
    assign ovf_unsigned = 1'b0;
    assign ovf_signed   = 1'b0;
  end

  assign ovf = smode_q ? ovf_signed : ovf_unsigned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      md_q     <= '0;
      acc_q    <= '0;
      mr_q     <= '0;
      cnt_q    <= '0;
      smode_q  <= 1'b0;
      sign_q   <= 1'b0;
      PP       <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            smode_q <= signed_mode;
            sign_q  <= signed_mode & (MD[WIDTH-1] ^ MR[WIDTH-1]);
            md_q    <= AW'(md_abs);
            mr_q    <= mr_abs;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy    <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          md_q  <= md_q << 1;
          mr_q  <= mr_q >> 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          PP       <= prod[OUT_WIDTH-1:0];
          zero     <= (acc_q == '0);
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          // Holding init keeps us here so a long strobe cannot retrigger.
          if (!init) begin
            done    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_nbits_seq.sv
// Directed bench: W=4/OUT=8 and W=4/OUT=6 share stimulus; a W=8/OUT=16 instance
// covers the wide signed corner.
module tb_mult_nbits_seq;

  logic        clk;
  logic        rst;
  logic        a_init;
  logic        a_sm;
  logic [3:0]  a_md;
  logic [3:0]  a_mr;
  logic [7:0]  a_pp;
  logic        a_done, a_busy, a_ovf, a_zero;
  logic [5:0]  b_pp;
  logic        b_done, b_busy, b_ovf, b_zero;
  logic        c_init;
  logic        c_sm;
  logic [7:0]  c_md;
  logic [7:0]  c_mr;
  logic [15:0] c_pp;
  logic        c_done, c_busy, c_ovf, c_zero;

  int total = 0;
  int bad   = 0;

  mult_nbits_seq #(.WIDTH(4), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .init(a_init), .signed_mode(a_sm), .MD(a_md), .MR(a_mr),
    .PP(a_pp), .done(a_done), .busy(a_busy), .overflow(a_ovf), .zero(a_zero)
  );

  mult_nbits_seq #(.WIDTH(4), .OUT_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .init(a_init), .signed_mode(a_sm), .MD(a_md), .MR(a_mr),
    .PP(b_pp), .done(b_done), .busy(b_busy), .overflow(b_ovf), .zero(b_zero)
  );

  mult_nbits_seq #(.WIDTH(8), .OUT_WIDTH(16)) dut_c (
    .clk(clk), .rst(rst), .init(c_init), .signed_mode(c_sm), .MD(c_md), .MR(c_mr),
    .PP(c_pp), .done(c_done), .busy(c_busy), .overflow(c_ovf), .zero(c_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start on the A/B pair, scramble inputs after the start edge, wait for done.
  task automatic run_ab(input logic sm, input logic [3:0] md, input logic [3:0] mr,
                        input int hold, input logic [7:0] e_pp, input logic e_ovf,
                        input logic e_zero, input logic [5:0] eb_pp, input logic eb_ovf,
                        input string tag);
    int lat;
    int nbusy;
    a_sm   = sm;
    a_md   = md;
    a_mr   = mr;
    a_init = 1'b1;
    @(posedge clk); #1;
    a_sm  = ~sm;
    a_md  = ~md;
    a_mr  = ~mr;
    lat   = 0;
    nbusy = a_busy ? 1 : 0;
    while (!a_done && lat < 20) begin
      if (lat + 1 >= hold) a_init = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (a_busy) nbusy++;
    end
    chk({tag, ".lat"},    32'(lat),    32'd5);
    chk({tag, ".busy"},   32'(nbusy),  32'd5);
    chk({tag, ".pp"},     32'(a_pp),   32'(e_pp));
    chk({tag, ".ovf"},    32'(a_ovf),  32'(e_ovf));
    chk({tag, ".zero"},   32'(a_zero), 32'(e_zero));
    chk({tag, ".b_done"}, 32'(b_done), 32'd1);
    chk({tag, ".b_pp"},   32'(b_pp),   32'(eb_pp));
    chk({tag, ".b_ovf"},  32'(b_ovf),  32'(eb_ovf));
    chk({tag, ".b_zero"}, 32'(b_zero), 32'(e_zero));
    if (!a_init) begin
      @(posedge clk); #1;
      chk({tag, ".idle"}, 32'(a_done), 32'd0);
    end
  endtask

  task automatic run_c(input logic sm, input logic [7:0] md, input logic [7:0] mr,
                       input logic [15:0] e_pp, input string tag);
    int lat;
    c_sm   = sm;
    c_md   = md;
    c_mr   = mr;
    c_init = 1'b1;
    @(posedge clk); #1;
    c_init = 1'b0;
    lat = 0;
    while (!c_done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},  32'(lat),    32'd9);
    chk({tag, ".pp"},   32'(c_pp),   32'(e_pp));
    chk({tag, ".ovf"},  32'(c_ovf),  32'd0);
    chk({tag, ".zero"}, 32'(c_zero), 32'd0);
    chk({tag, ".busy"}, 32'(c_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; a_init = 1'b0; a_sm = 1'b0; a_md = '0; a_mr = '0;
    c_init = 1'b0; c_sm = 1'b0; c_md = '0; c_mr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.a_pp",   32'(a_pp),   32'd0);
    chk("rst.a_done", 32'(a_done), 32'd0);
    chk("rst.a_busy", 32'(a_busy), 32'd0);
    chk("rst.a_ovf",  32'(a_ovf),  32'd0);
    chk("rst.a_zero", 32'(a_zero), 32'd0);
    chk("rst.b_busy", 32'(b_busy), 32'd0);
    chk("rst.c_pp",   32'(c_pp),   32'd0);
    chk("rst.c_busy", 32'(c_busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_ab(1'b0, 4'd3,    4'd3,    1, 8'h09, 1'b0, 1'b0, 6'h09, 1'b0, "u3x3");
    run_ab(1'b1, 4'b1110, 4'b0011, 1, 8'hFA, 1'b0, 1'b0, 6'h3A, 1'b0, "s-2x3");
    run_ab(1'b1, 4'b1000, 4'b1000, 1, 8'h40, 1'b0, 1'b0, 6'h00, 1'b1, "s-8x-8");
    run_ab(1'b1, 4'b1000, 4'b0111, 1, 8'hC8, 1'b0, 1'b0, 6'h08, 1'b1, "s-8x7");
    run_ab(1'b0, 4'd0,    4'd7,    1, 8'h00, 1'b0, 1'b1, 6'h00, 1'b0, "u0x7");
    run_ab(1'b0, 4'd6,    4'd7,    2, 8'h2A, 1'b0, 1'b0, 6'h2A, 1'b0, "u6x7h2");
    run_ab(1'b0, 4'd15,   4'd15,   1, 8'hE1, 1'b0, 1'b0, 6'h21, 1'b1, "u15x15");

    // init held through DONE must not restart
    run_ab(1'b0, 4'd2, 4'd3, 1000, 8'h06, 1'b0, 1'b0, 6'h06, 1'b0, "u2x3held");
    repeat (3) @(posedge clk);
    #1;
    chk("held.done", 32'(a_done), 32'd1);
    chk("held.busy", 32'(a_busy), 32'd0);
    chk("held.pp",   32'(a_pp),   32'h06);
    a_init = 1'b0;
    @(posedge clk); #1;
    chk("held.release", 32'(a_done), 32'd0);
    run_ab(1'b1, 4'd3, 4'b1111, 1, 8'hFD, 1'b0, 1'b0, 6'h3D, 1'b0, "s3x-1");

    // reset in the second CALC cycle discards the operation
    a_sm = 1'b0; a_md = 4'd7; a_mr = 4'd7; a_init = 1'b1;
    @(posedge clk); #1;
    a_init = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.busy", 32'(a_busy), 32'd0);
    chk("midrst.done", 32'(a_done), 32'd0);
    chk("midrst.pp",   32'(a_pp),   32'd0);
    chk("midrst.b_pp", 32'(b_pp),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_ab(1'b0, 4'd5, 4'd4, 1, 8'h14, 1'b0, 1'b0, 6'h14, 1'b0, "u5x4");

    // reset wins over a simultaneous start
    rst = 1'b1; a_init = 1'b1; a_md = 4'd3; a_mr = 4'd3;
    @(posedge clk); #1;
    chk("rstinit.busy", 32'(a_busy), 32'd0);
    rst = 1'b0; a_init = 1'b0;
    @(posedge clk); #1;

    run_c(1'b1, 8'h80, 8'h80, 16'h4000, "c.s-128x-128");
    run_c(1'b0, 8'hFF, 8'hFF, 16'hFE01, "c.u255x255");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
